// File: rtl/slc3_mem_pkg.sv
// rtl/slc3_mem_pkg.sv - shared types and constants for the SLC-3 SRAM responder
// Purpose: FSM state encoding, data word width and the zero word used by the array clear.
// Contents: mem_state_t, WORD_W, ZERO_WORD.
package slc3_mem_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WR_HOLD,
    RD_WAIT,
    RD_VALID
  } mem_state_t;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] ZERO_WORD = 16'h0000;

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - synchronous single-port RAM with registered read
// Purpose: storage for the SRAM responder; one read or write per cycle.
// Ports: Clk clock; we write enable; addr word address; wdata write data;
//        rdata registered read data of the word addressed on the previous edge.
module sram_array
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  Clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] r_mem [2**DEPTH_LOG2];

  // Read-before-write: rdata shows the old contents on a write cycle.
  always_ff @(posedge Clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/slc3_sram_responder.sv
// rtl/slc3_sram_responder.sv - memory-side responder for the SLC-3 external SRAM bus
// Purpose: answers OE/WE/ADDR/Data_to_SRAM requests with Data_from_SRAM after READ_LAT edges,
//          zero-fills the array after every reset before honouring requests.
// Ports: Clk clock; Reset async active-high; OE/WE active-low enables; ADDR word address;
//        Data_to_SRAM write data; Data_from_SRAM read data (0 outside a valid read);
//        Ready clear complete; Addr_Err sticky out-of-range access flag.
module slc3_sram_responder
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int READ_LAT   = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              OE,
  input  logic              WE,
  input  logic [15:0]       ADDR,
  input  logic [15:0]       Data_to_SRAM,
  output logic [15:0]       Data_from_SRAM,
  output logic              Ready,
  output logic              Addr_Err
);

  localparam logic [2:0] LAT_RELOAD = 3'(READ_LAT - 1);
  // With a one-cycle latency there is no wait phase at all.
  localparam mem_state_t RD_ENTRY = (READ_LAT == 1) ? RD_VALID : RD_WAIT;

  mem_state_t            r_state;
  logic [DEPTH_LOG2-1:0] r_clr_addr;
  logic [2:0]            r_lat_cnt;
  logic [15:0]           r_rd_addr;
  logic                  r_rd_oor;
  logic [WORD_W-1:0]     r_dout;
  logic                  r_ready;
  logic                  r_addr_err;

  logic                  w_oor;
  logic                  w_addr_chg;
  logic                  w_ram_we;
  logic [DEPTH_LOG2-1:0] w_ram_addr;
  logic [WORD_W-1:0]     w_ram_wdata;
  logic [WORD_W-1:0]     w_ram_rdata;

  assign w_oor      = ((32'(ADDR) >> DEPTH_LOG2) != 32'd0);
  assign w_addr_chg = (ADDR != r_rd_addr);

  // The RAM always reads the live ADDR outside CLEAR. A read only reaches
  // RD_VALID with ADDR unchanged since the latch, so rdata matches rd_addr.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = ADDR[DEPTH_LOG2-1:0];
    w_ram_wdata = Data_to_SRAM;
    if (r_state == CLEAR) begin
      w_ram_we    = 1'b1;
      w_ram_addr  = r_clr_addr;
      w_ram_wdata = ZERO_WORD;
    end else if (r_state == IDLE && !WE && !w_oor) begin
      w_ram_we = 1'b1;
    end
  end

  sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .Clk  (Clk),
    .we   (w_ram_we),
    .addr (w_ram_addr),
    .wdata(w_ram_wdata),
    .rdata(w_ram_rdata)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_lat_cnt  <= '0;
      r_rd_addr  <= '0;
      r_rd_oor   <= 1'b0;
      r_dout     <= ZERO_WORD;
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_dout <= ZERO_WORD;
      if (r_state != CLEAR && (!WE || !OE) && w_oor) begin
        r_addr_err <= 1'b1;
      end
      case (r_state)
        CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == '1) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (!WE) begin
            r_state <= WR_HOLD;
          end else if (!OE) begin
            r_rd_addr <= ADDR;
            r_rd_oor  <= w_oor;
            r_lat_cnt <= LAT_RELOAD;
            r_state   <= RD_ENTRY;
          end
        end
        WR_HOLD: begin
          if (WE) begin
            r_state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (!WE || OE) begin
            r_state <= IDLE;
          end else if (w_addr_chg) begin
            r_rd_addr <= ADDR;
            r_rd_oor  <= w_oor;
            r_lat_cnt <= LAT_RELOAD;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
            if (r_lat_cnt == 3'd1) begin
              r_state <= RD_VALID;
            end
          end
        end
        RD_VALID: begin
          if (!WE || OE) begin
            r_state <= IDLE;
          end else if (w_addr_chg) begin
            r_rd_addr <= ADDR;
            r_rd_oor  <= w_oor;
            r_lat_cnt <= LAT_RELOAD;
            r_state   <= RD_ENTRY;
          end else begin
            r_dout <= r_rd_oor ? ZERO_WORD : w_ram_rdata;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign Data_from_SRAM = r_dout;
  assign Ready          = r_ready;
  assign Addr_Err       = r_addr_err;

endmodule
